// File: rtl/repeat_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : repeat_seq_ctrl
// Purpose  : Run-time controller for a repeated-value count sequencer.
//            Produces 0 (x rpt), 1 (x rpt) .. max (x rpt) in one-shot or
//            continuous mode, with start / pause / abort sequencing and
//            step / wrap / done status strobes.
// Ports    : clk, rst                  - clock, synchronous active-high reset
//            cfg_wr, cfg_max, cfg_rpt,
//            cfg_cont                  - configuration write (IDLE only)
//            start, pause, abort       - sequencing commands
//            cnt, cnt_vld              - stepped count and its qualifier
//            step, wrap, done          - one-cycle status strobes
//            busy, cfg_err             - activity flag, sticky config error
// Revision : 1.0 - initial release
// ============================================================================
module repeat_seq_ctrl #(
   parameter int N       = 4,
   parameter int RPT_W   = 4,
   parameter int DEF_MAX = 9,
   parameter int DEF_RPT = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_wr,
   input  logic [N-1:0]     cfg_max,
   input  logic [RPT_W-1:0] cfg_rpt,
   input  logic             cfg_cont,
   input  logic             start,
   input  logic             pause,
   input  logic             abort,
   output logic [N-1:0]     cnt,
   output logic             cnt_vld,
   output logic             step,
   output logic             wrap,
   output logic             done,
   output logic             busy,
   output logic             cfg_err
);

   localparam logic [N-1:0]     c_def_max = N'(DEF_MAX);
   localparam logic [RPT_W-1:0] c_def_rpt = RPT_W'(DEF_RPT);
   localparam logic [RPT_W-1:0] c_rcnt_1  = RPT_W'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_HOLD = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [N-1:0]     r_cnt;
   logic [N-1:0]     w_cnt_nxt;
   logic [RPT_W-1:0] r_rcnt;
   logic [RPT_W-1:0] w_rcnt_nxt;
   logic             r_step;
   logic             w_step_nxt;
   logic             r_wrap;
   logic             w_wrap_nxt;
   logic [N-1:0]     r_max;
   logic [RPT_W-1:0] r_rpt;
   logic             r_cont;
   logic             r_err;
   logic             w_cfg_ok;

   // A config write is judged on the current state alone; a zero repeat
   // count would never let the sequence advance, so it is refused.
   assign w_cfg_ok = (r_state == S_IDLE) && (cfg_rpt != '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_rcnt  <= c_rcnt_1;
         r_step  <= 1'b0;
         r_wrap  <= 1'b0;
         r_max   <= c_def_max;
         r_rpt   <= c_def_rpt;
         r_cont  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_rcnt  <= w_rcnt_nxt;
         r_step  <= w_step_nxt;
         r_wrap  <= w_wrap_nxt;
         if (cfg_wr) begin
            if (w_cfg_ok) begin
               r_max  <= cfg_max;
               r_rpt  <= cfg_rpt;
               r_cont <= cfg_cont;
               r_err  <= 1'b0;
            end else begin
               r_err  <= 1'b1;
            end
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_rcnt_nxt  = r_rcnt;
      w_step_nxt  = 1'b0;
      w_wrap_nxt  = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_cnt_nxt  = '0;
            w_rcnt_nxt = c_rcnt_1;
            // abort and pause outrank start, so either one blocks a launch
            if (!abort && !pause && start) begin
               w_state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            if (abort) begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = '0;
               w_rcnt_nxt  = c_rcnt_1;
            end else if (pause) begin
               // rcnt is left untouched so the resume continues mid-hold
               w_state_nxt = S_HOLD;
            end else if (r_rcnt != r_rpt) begin
               w_rcnt_nxt = r_rcnt + c_rcnt_1;
            end else if (r_cnt != r_max) begin
               w_rcnt_nxt = c_rcnt_1;
               w_cnt_nxt  = r_cnt + N'(1);
               w_step_nxt = 1'b1;
            end else if (r_cont) begin
               w_rcnt_nxt = c_rcnt_1;
               w_cnt_nxt  = '0;
               w_step_nxt = 1'b1;
               w_wrap_nxt = 1'b1;
            end else begin
               w_state_nxt = S_DONE;
               w_cnt_nxt   = '0;
               w_rcnt_nxt  = c_rcnt_1;
            end
         end
         S_HOLD: begin
            if (abort) begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = '0;
               w_rcnt_nxt  = c_rcnt_1;
            end else if (!pause) begin
               w_state_nxt = S_RUN;
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_rcnt_nxt  = c_rcnt_1;
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_rcnt_nxt  = c_rcnt_1;
         end
      endcase
   end

   // All outputs come straight from flops or from a decode of the state flop.
   assign cnt     = r_cnt;
   assign cnt_vld = (r_state == S_RUN);
   assign step    = r_step;
   assign wrap    = r_wrap;
   assign done    = (r_state == S_DONE);
   assign busy    = (r_state != S_IDLE);
   assign cfg_err = r_err;

endmodule
`default_nettype wire
